// File: rtl/generic_sram_byte_en_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enable SRAM between NUM_REQ requesters,
// with optional burst lock, forced release after MAX_HOLD cycles and in-order read return.
module generic_sram_byte_en_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int MEM_ADDR_BITS = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 1,
  parameter int MAX_HOLD      = 16,
  localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ-1:0]                 req_lock,
  input  logic [NUM_REQ*MEM_ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*BE_WIDTH-1:0]        req_byte_en,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic [MEM_ADDR_BITS-1:0]           sram_addr,
  output logic                               sram_write_en,
  output logic                               sram_read_en,
  output logic [BE_WIDTH-1:0]                sram_byte_en,
  output logic [DATA_WIDTH-1:0]              sram_write_data,
  input  logic [DATA_WIDTH-1:0]              sram_read_data
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic                                active_q, active_d;
  logic [ID_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic                                lock_active_q, lock_active_d;
  logic [ID_W-1:0]                     lock_id_q, lock_id_d;
  logic [HOLD_W-1:0]                   hold_cnt_q, hold_cnt_d;
  logic [READ_LATENCY-1:0]             pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][ID_W-1:0]   pipe_id_q, pipe_id_d;

  logic [NUM_REQ-1:0]                  grant_s;
  logic [ID_W-1:0]                     gnt_id_s;
  logic [ID_W-1:0]                     scan_id_s;
  logic                                fire_s;
  logic                                fire_write_s;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      next_id = '0;
    end else begin
      next_id = id + ID_W'(1);
    end
  endfunction

  // Grant selection: locked owner only, else first valid requester from rr_ptr upward.
  always_comb begin
    grant_s   = '0;
    gnt_id_s  = '0;
    scan_id_s = '0;
    fire_s    = 1'b0;
    if (active_q) begin
      if (lock_active_q) begin
        gnt_id_s = lock_id_q;
        fire_s   = req_valid[lock_id_q];
      end else begin
        // Scan from the far end so the requester closest to rr_ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          scan_id_s = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
          gnt_id_s  = req_valid[scan_id_s] ? scan_id_s : gnt_id_s;
          fire_s    = fire_s | req_valid[scan_id_s];
        end
      end
      grant_s[gnt_id_s] = fire_s;
    end else begin
      grant_s = '0;
    end
  end

  // SRAM command mux from the granted requester's slices.
  always_comb begin
    fire_write_s    = req_write[gnt_id_s];
    req_ready       = grant_s;
    sram_write_en   = fire_s & fire_write_s;
    sram_read_en    = fire_s & ~fire_write_s;
    sram_addr       = '0;
    sram_byte_en    = '0;
    sram_write_data = '0;
    if (fire_s) begin
      sram_addr       = req_addr[gnt_id_s*MEM_ADDR_BITS +: MEM_ADDR_BITS];
      sram_write_data = req_wdata[gnt_id_s*DATA_WIDTH +: DATA_WIDTH];
      sram_byte_en    = fire_write_s ? req_byte_en[gnt_id_s*BE_WIDTH +: BE_WIDTH] : '1;
    end else begin
      sram_addr = '0;
    end
  end

  // Lock ownership, hold counter and round-robin pointer update.
  always_comb begin
    active_d      = 1'b1;
    rr_ptr_d      = rr_ptr_q;
    lock_active_d = lock_active_q;
    lock_id_d     = lock_id_q;
    hold_cnt_d    = hold_cnt_q;
    if (lock_active_q) begin
      if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
        lock_active_d = 1'b0;
        hold_cnt_d    = '0;
        rr_ptr_d      = next_id(lock_id_q);
      end else if (fire_s && !req_lock[gnt_id_s]) begin
        lock_active_d = 1'b0;
        hold_cnt_d    = '0;
        rr_ptr_d      = next_id(gnt_id_s);
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    end else if (fire_s) begin
      if (req_lock[gnt_id_s]) begin
        lock_active_d = 1'b1;
        lock_id_d     = gnt_id_s;
        hold_cnt_d    = '0;
      end else begin
        rr_ptr_d = next_id(gnt_id_s);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Read-return shift pipe: tags each read with its issuer for READ_LATENCY cycles.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_id_d     = pipe_id_q;
    pipe_vld_d[0] = fire_s & ~fire_write_s;
    pipe_id_d[0]  = gnt_id_s;
    for (int j = 1; j < READ_LATENCY; j++) begin
      pipe_vld_d[j] = pipe_vld_q[j-1];
      pipe_id_d[j]  = pipe_id_q[j-1];
    end
  end

  // Response demux; read data is passed straight through from the SRAM.
  always_comb begin
    rsp_valid                             = '0;
    rsp_valid[pipe_id_q[READ_LATENCY-1]]  = pipe_vld_q[READ_LATENCY-1];
    rsp_data                              = sram_read_data;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      rr_ptr_q      <= '0;
      lock_active_q <= 1'b0;
      lock_id_q     <= '0;
      hold_cnt_q    <= '0;
      pipe_vld_q    <= '0;
      pipe_id_q     <= '0;
    end else begin
      active_q      <= active_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_active_q <= lock_active_d;
      lock_id_q     <= lock_id_d;
      hold_cnt_q    <= hold_cnt_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_id_q     <= pipe_id_d;
    end
  end

endmodule

// File: tb/tb_generic_sram_byte_en_arbiter.sv
// Directed bench: instance a (READ_LATENCY=1, MAX_HOLD=4) and instance b (READ_LATENCY=2)
// share stimulus; each step compares outputs against hand-computed values.
module tb_generic_sram_byte_en_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [1:0]  req_lock;
  logic [19:0] req_addr;
  logic [7:0]  req_byte_en;
  logic [63:0] req_wdata;
  logic [31:0] sram_read_data;

  logic [1:0]  a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [31:0] a_rsp_data, b_rsp_data, a_wdata, b_wdata;
  logic [9:0]  a_addr, b_addr;
  logic        a_wr_en, b_wr_en, a_rd_en, b_rd_en;
  logic [3:0]  a_be, b_be;

  int n_assert = 0;
  int n_fail   = 0;

  generic_sram_byte_en_arbiter #(.NUM_REQ(2), .MEM_ADDR_BITS(10), .DATA_WIDTH(32),
                                 .READ_LATENCY(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_ready),
    .req_write(req_write), .req_lock(req_lock), .req_addr(req_addr),
    .req_byte_en(req_byte_en), .req_wdata(req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .sram_addr(a_addr), .sram_write_en(a_wr_en),
    .sram_read_en(a_rd_en), .sram_byte_en(a_be), .sram_write_data(a_wdata),
    .sram_read_data(sram_read_data)
  );

  generic_sram_byte_en_arbiter #(.NUM_REQ(2), .MEM_ADDR_BITS(10), .DATA_WIDTH(32),
                                 .READ_LATENCY(2), .MAX_HOLD(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_ready),
    .req_write(req_write), .req_lock(req_lock), .req_addr(req_addr),
    .req_byte_en(req_byte_en), .req_wdata(req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .sram_addr(b_addr), .sram_write_en(b_wr_en),
    .sram_read_en(b_rd_en), .sram_byte_en(b_be), .sram_write_data(b_wdata),
    .sram_read_data(sram_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lock-burst (0..4), forced release (5..10), forced release with honoured fire (11..16).
  logic [1:0] t_valid [17] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10,
                               2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                               2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
  logic [1:0] t_lock  [17] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [1:0] t_exp   [17] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                               2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                               2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid      = 2'b11;
    req_write      = 2'b00;
    req_lock       = 2'b00;
    req_addr       = '0;
    req_byte_en    = '0;
    req_wdata      = '0;
    sram_read_data = '0;

    // Outputs held at zero during reset even with requests pending
    @(negedge clk);
    chk("rst_ready_a", a_ready, 2'b00);
    chk("rst_ready_b", b_ready, 2'b00);
    chk("rst_rd_en", a_rd_en, 1'b0);
    chk("rst_wr_en", a_wr_en, 1'b0);
    chk("rst_rsp_valid", a_rsp_valid, 2'b00);
    chk("rst_addr", a_addr, 10'h000);
    chk("rst_be", a_be, 4'h0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    next_cycle();

    // Single read by req0
    req_addr  = {10'h000, 10'h010};
    req_valid = 2'b01;
    @(negedge clk);
    chk("rd_ready", a_ready, 2'b01);
    chk("rd_en", a_rd_en, 1'b1);
    chk("rd_addr", a_addr, 10'h010);
    chk("rd_be", a_be, 4'hF);
    chk("rd_rsp_early", a_rsp_valid, 2'b00);
    next_cycle();
    req_valid      = 2'b00;
    sram_read_data = 32'hA5A5_0001;
    @(negedge clk);
    chk("rd_rsp_valid", a_rsp_valid, 2'b01);
    chk("rd_rsp_data", a_rsp_data, 32'hA5A5_0001);
    next_cycle();
    @(negedge clk);
    chk("rd_rsp_after", a_rsp_valid, 2'b00);

    // Round-robin from reset with both requesters reading
    do_reset();
    req_addr = {10'h021, 10'h020};
    for (int k = 0; k < 5; k++) begin
      req_valid      = (k < 4) ? 2'b11 : 2'b00;
      sram_read_data = 32'hD000_0000 + 32'(k);
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("rr_ready[%0d]", k), a_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("rr_addr[%0d]", k), a_addr, (k % 2 == 0) ? 10'h020 : 10'h021);
      end
      if (k > 0) begin
        chk($sformatf("rr_rsp[%0d]", k), a_rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk($sformatf("rr_rsp_data[%0d]", k), a_rsp_data, 32'hD000_0000 + 32'(k));
      end
      next_cycle();
    end

    // Write strobes from req1
    req_valid   = 2'b10;
    req_write   = 2'b10;
    req_addr    = {10'h3FF, 10'h000};
    req_byte_en = {4'b0101, 4'b0000};
    req_wdata   = {32'h1122_3344, 32'h0};
    @(negedge clk);
    chk("wr_ready", a_ready, 2'b10);
    chk("wr_en", a_wr_en, 1'b1);
    chk("wr_rd_en", a_rd_en, 1'b0);
    chk("wr_be", a_be, 4'b0101);
    chk("wr_addr", a_addr, 10'h3FF);
    chk("wr_data", a_wdata, 32'h1122_3344);
    next_cycle();
    req_valid = 2'b00;
    req_write = 2'b00;
    @(negedge clk);
    chk("wr_no_rsp", a_rsp_valid, 2'b00);
    next_cycle();

    // Lock burst, forced release, forced release with a fire in the release cycle
    req_addr = {10'h111, 10'h100};
    for (int i = 0; i < 17; i++) begin
      req_valid = t_valid[i];
      req_lock  = t_lock[i];
      @(negedge clk);
      chk($sformatf("lock_ready[%0d]", i), a_ready, t_exp[i]);
      chk($sformatf("lock_rd_en[%0d]", i), a_rd_en, |t_exp[i]);
      next_cycle();
    end
    req_valid = 2'b00;
    req_lock  = 2'b00;

    // Reset asserted the cycle after a read fires (READ_LATENCY=2 instance)
    do_reset();
    req_addr  = {10'h000, 10'h055};
    req_valid = 2'b01;
    @(negedge clk);
    chk("mid_ready_fire", b_ready, 2'b01);
    chk("mid_rd_en_fire", b_rd_en, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_ready_rst", b_ready, 2'b00);
    chk("mid_rd_en_rst", b_rd_en, 1'b0);
    chk("mid_addr_rst", b_addr, 10'h000);
    chk("mid_rsp_rst", b_rsp_valid, 2'b00);
    next_cycle();
    chk("mid_rsp_drop", b_rsp_valid, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_release", b_ready, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("mid_first_grant", b_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_rsp_none", b_rsp_valid, 2'b00);
    next_cycle();
    sram_read_data = 32'h5555_AAAA;
    @(negedge clk);
    chk("mid_rsp_new", b_rsp_valid, 2'b01);
    chk("mid_rsp_data", b_rsp_data, 32'h5555_AAAA);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
